// File: rtl/asip_pkg.sv
// asip_pkg: shared widths, arbiter state encoding and read-tag encoding for ram_port_arbiter
package asip_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 48;
  typedef enum logic [1:0] {IDLE, CPU, HOST} arb_state_t;
  typedef enum logic {TAG_CPU = 1'b0, TAG_HOST = 1'b1} rd_tag_t;
endpackage

// File: rtl/arb_grant_fsm.sv
// arb_grant_fsm: grant decision, host burst lock and optional host starvation guard
// Ports: clk, reset (async, active-high); i_cpu_req, i_host_req in;
//        o_cpu_gnt, o_host_gnt out (combinational, mutually exclusive).
// Optional feature: RAM_ARB_STARVE_GUARD_EN adds a forced host grant after STARVE_LIMIT denied cycles.
module arb_grant_fsm
  import asip_pkg::*;
#(
  parameter int HOST_BURST_MAX = 8,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_host_req,
  output logic o_cpu_gnt,
  output logic o_host_gnt
);
  localparam int BW = $clog2(HOST_BURST_MAX + 1);
  arb_state_t    r_state;
  logic [BW-1:0] r_burst;
  logic          w_lock;
  logic          w_force;
  // host keeps the port while it still asks and has burst budget left
  assign w_lock = (r_state == HOST) && i_host_req && (r_burst < BW'(HOST_BURST_MAX));
`ifdef RAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  assign w_force = i_host_req && (r_starve == SW'(STARVE_LIMIT));
  // a forced grant always clears the counter, so it never runs past the limit
  always_ff @(posedge clk or posedge reset)
    if (reset) r_starve <= '0;
    else r_starve <= (!i_host_req || o_host_gnt) ? '0 : r_starve + 1'b1;
`else
  assign w_force = 1'b0;
`endif
  // grants are masked while reset is held so no RAM write can slip through
  assign o_host_gnt = !reset && (w_force || w_lock || (i_host_req && !i_cpu_req));
  assign o_cpu_gnt  = !reset && i_cpu_req && !o_host_gnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_burst <= '0;
    end else begin
      r_state <= o_host_gnt ? HOST : o_cpu_gnt ? CPU : IDLE;
      r_burst <= !o_host_gnt ? '0 : (r_burst == BW'(HOST_BURST_MAX)) ? r_burst : r_burst + 1'b1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between a processor and a host loader/dumper
// Ports: clk, reset (async, active-high);
//   cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_stall/cpu_rdata/cpu_rvalid out;
//   host_req/host_we/host_addr/host_wdata in, host_gnt/host_rdata/host_rvalid out;
//   mem_addr/mem_wdata/mem_we out, mem_rdata in (valid one cycle after the address).
// Optional feature: define RAM_ARB_STARVE_GUARD_EN to enable the host starvation guard.
module ram_port_arbiter
  import asip_pkg::*;
#(
  parameter int HOST_BURST_MAX = 8,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic              w_cpu_gnt;
  logic              w_host_gnt;
  logic              r_rd_pend;
  rd_tag_t           r_rd_tag;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  arb_grant_fsm #(
    .HOST_BURST_MAX(HOST_BURST_MAX),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .i_cpu_req (cpu_req),
    .i_host_req(host_req),
    .o_cpu_gnt (w_cpu_gnt),
    .o_host_gnt(w_host_gnt)
  );
  // address/data go straight to the RAM on a grant so data returns next cycle; idle cycles replay the last values
  assign mem_addr    = w_cpu_gnt ? cpu_addr : w_host_gnt ? host_addr : r_addr;
  assign mem_wdata   = w_cpu_gnt ? cpu_wdata : w_host_gnt ? host_wdata : r_wdata;
  assign mem_we      = (w_cpu_gnt && cpu_we) || (w_host_gnt && host_we);
  assign cpu_stall   = cpu_req && !w_cpu_gnt;
  assign host_gnt    = w_host_gnt;
  assign cpu_rvalid  = r_rd_pend && (r_rd_tag == TAG_CPU);
  assign host_rvalid = r_rd_pend && (r_rd_tag == TAG_HOST);
  // the RAM output is forwarded during the pulse and captured so it stays put afterwards
  assign cpu_rdata   = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign host_rdata  = host_rvalid ? mem_rdata : r_host_rdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rd_pend    <= 1'b0;
      r_rd_tag     <= TAG_CPU;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_rd_pend <= (w_cpu_gnt && !cpu_we) || (w_host_gnt && !host_we);
      r_rd_tag  <= w_host_gnt ? TAG_HOST : TAG_CPU;
      r_addr    <= mem_addr;
      r_wdata   <= mem_wdata;
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (host_rvalid) r_host_rdata <= mem_rdata;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameters: HOST_BURST_MAX, default 8, maximum consecutive host grants per lock; STARVE_LIMIT, default 16, consecutive denied host cycles before a forced host grant.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cpu_req  in  1  processor access request.
- cpu_we  in  1  processor write.
- cpu_addr  in  16  processor word address.
- cpu_wdata  in  48  processor write data.
- cpu_stall  out  1  processor request not granted this cycle.
- cpu_rdata  out  48  processor read data.
- cpu_rvalid  out  1  cpu_rdata valid.
- host_req  in  1  host (loader/dumper) request.
- host_we  in  1  host write.
- host_addr  in  16  host word address.
- host_wdata  in  48  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rdata  out  48  host read data.
- host_rvalid  out  1  host_rdata valid.
- mem_addr  out  16  RAM address.
- mem_wdata  out  48  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_rdata  in  48  RAM read data, one cycle after address.

Function
REQ-003 SHALL use FSM states IDLE, CPU, HOST; the state holds the owner of the previous cycle's grant.
REQ-004 SHALL grant at most one requester per cycle; grant decision combinational from state, requests and counters.
REQ-005 SHALL, in IDLE or CPU, grant CPU when cpu_req=1, else grant host when host_req=1, else grant none.
REQ-006 SHALL, in HOST, keep host granted while host_req=1 and burst count < HOST_BURST_MAX (lock); at limit with cpu_req=1, grant CPU for at least one cycle.
REQ-007 SHALL count consecutive host grants in a burst counter, cleared on any non-host cycle.
REQ-008 SHALL drive mem_addr/mem_wdata/mem_we from the granted requester; with no grant, mem_we=0 and mem_addr/mem_wdata hold their last values.
REQ-009 SHALL assert cpu_stall = cpu_req & ~cpu granted; host_gnt = host granted.
REQ-010 SHALL register a one-bit read tag for each granted read; next cycle pass mem_rdata to that requester's rdata and pulse its rvalid for one cycle.
REQ-011 SHALL hold cpu_rdata/host_rdata stable between rvalid pulses.
REQ-012 SHALL not assert rvalid for granted writes.
REQ-013 SHALL make back-to-back grants to alternating requesters each return data on the correct rdata port.
REQ-014 SHALL ignore a host_req that drops mid-burst: next cycle follows the REQ-005 rules, and the burst counter clears.

Reset
REQ-015 SHALL on reset, asynchronously: state=IDLE; counters=0; read tag cleared; cpu_rvalid=host_rvalid=0; cpu_rdata=host_rdata=0; mem_we=0; mem_addr=mem_wdata=0; host_gnt=0.
REQ-016 SHALL, if reset asserts during a host burst or with a read outstanding, discard the pending rvalid; the first cycle after release obeys REQ-005.

Configuration
REQ-017 SHALL support macro RAM_ARB_STARVE_GUARD_EN. When defined: a counter counts cycles with host_req=1 and host not granted; when it reaches STARVE_LIMIT, the host is granted next cycle over cpu_req, and the counter clears on any host grant or host_req=0. When undefined: no counter, and the host wins only when cpu_req=0 or through the REQ-006 lock.

Structure
REQ-018 SHALL place the state enum, the ADDR_W=16 and DATA_W=48 constants, and the read-tag encoding in shared package asip_pkg.
REQ-019 SHALL keep the grant logic and counters in one sub-module, arb_grant_fsm; the datapath muxes and read-return registers stay in ram_port_arbiter.

Verification
REQ-020 SHALL verify: cpu_req=1 and host_req=1 from IDLE -> CPU granted, cpu_stall=0, host_gnt=0.
REQ-021 SHALL verify: host read addr 0x0010 alone, mem_rdata=0x0000_0000_ABCD -> host_gnt=1 at cycle 0; host_rvalid=1 and host_rdata=0x0000_0000_ABCD at cycle 1.
REQ-022 SHALL verify: host holds 10 cycles and cpu_req rises at cycle 2 -> host granted cycles 0-7 with cpu_stall=1, CPU granted cycle 8.
REQ-023 SHALL verify: with the guard compiled in and cpu_req=1 held continuously, host_req=1 -> host_gnt=1 exactly 16 cycles later; without the macro -> host_gnt never asserts.
REQ-024 SHALL verify: reset asserted one cycle after a granted CPU read -> cpu_rvalid stays 0 and all outputs match REQ-015 immediately.
REQ-025 SHALL verify: alternating CPU read 0x0001 and host read 0x0002 with cpu_req dropped every other cycle -> each rvalid pulses only on its own port with the matching data.
